expansion_shiftreg_multi: RTL and testbench

//  Parametrised successor of the 8-bit expansion shift register: drives one daisy chain of
//  74HC595 (outputs) and 74HC165 (inputs) with independent in/out widths, frame FSM, safe-state

---
 rtl/rio_expansion_pkg.sv | 23 ++
 rtl/expansion_debounce.sv | 41 ++++
 rtl/expansion_shiftreg_multi.sv | 155 +++++++++++++++
 tb/tb_expansion_shiftreg_multi.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rio_expansion_pkg.sv
// Shared state type and elaboration-time width helpers for the expansion shift-register chain.
package rio_expansion_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    LATCH = 2'd3
  } state_t;

  function automatic int unsigned max_w(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Bits needed to hold 0..count-1, never less than one.
  function automatic int unsigned log2_w(input int unsigned count);
    int unsigned w;
    w = 1;
    while ((64'd1 << w) < 64'(count)) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/expansion_debounce.sv
// Per-bit frame-count debounce: a bit follows the raw capture only after DEPTH consecutive
// frames disagreeing with its current value; any agreeing frame clears that bit's count.
module expansion_debounce
  import rio_expansion_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             strobe,
  input  logic [WIDTH-1:0] raw,
  input  logic [WIDTH-1:0] current,
  output logic [WIDTH-1:0] filtered_c
);

  localparam int unsigned CNT_W = log2_w(DEPTH);

  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      filtered_c[i] = current[i];
      cnt_d[i]      = '0;
      if (raw[i] != current[i]) begin
        if (cnt_q[i] == CNT_W'(DEPTH - 1)) filtered_c[i] = raw[i];
        else                               cnt_d[i]      = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else if (strobe) begin
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

endmodule

// File: rtl/expansion_shiftreg_multi.sv
// Drives one 74HC595/74HC165 daisy chain: frame FSM, safe-state substitution, frame strobes.
// Input debouncing is built only when EXPANSION_SHIFTREG_DEBOUNCE_EN is defined.
module expansion_shiftreg_multi
  import rio_expansion_pkg::*;
#(
  parameter int unsigned          IN_WIDTH   = 8,
  parameter int unsigned          OUT_WIDTH  = 8,
  parameter int unsigned          DIVIDER    = 135,
  parameter logic [OUT_WIDTH-1:0] SAFE_VALUE = '0,
  parameter int unsigned          DEB_FRAMES = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 safe,
  input  logic [OUT_WIDTH-1:0] data_out,
  output logic [IN_WIDTH-1:0]  data_in,
  output logic                 frame_done,
  output logic                 in_changed,
  output logic                 SHIFT_OUT,
  input  logic                 SHIFT_IN,
  output logic                 SHIFT_CLK,
  output logic                 SHIFT_LOAD
);

  localparam int unsigned N      = max_w(IN_WIDTH, OUT_WIDTH);
  localparam int unsigned PHASES = 2 * N;
  localparam int unsigned DIV_W  = log2_w(DIVIDER);
  localparam int unsigned PH_W   = log2_w(PHASES);

  if (IN_WIDTH < 1 || IN_WIDTH > 64 || OUT_WIDTH < 1 || OUT_WIDTH > 64 ||
      DIVIDER < 2 || DEB_FRAMES < 1) begin : g_bad_param
    $error("expansion_shiftreg_multi: parameter out of range");
  end

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_q;
  logic [PH_W-1:0]     phase_q, phase_d;
  logic [N-1:0]        tx_q, tx_d, rx_q, rx_d, tx_snap_c;
  logic                sclk_d, sload_d, sout_d;
  logic                tick_c, frame_end_c;
  logic [IN_WIDTH-1:0] raw_c, next_in_c;

  assign tick_c      = (div_q == DIV_W'(DIVIDER - 1));
  assign frame_end_c = tick_c && (state_q == LATCH);
  // Zero-extension places the padding at the MSB end so it is shifted out first.
  assign tx_snap_c   = N'(safe ? SAFE_VALUE : data_out);
  assign raw_c       = rx_q[IN_WIDTH-1:0];

`ifdef EXPANSION_SHIFTREG_DEBOUNCE_EN
  expansion_debounce #(
    .WIDTH (IN_WIDTH),
    .DEPTH (DEB_FRAMES)
  ) u_debounce (
    .clk        (clk),
    .rst_n      (rst_n),
    .strobe     (frame_end_c),
    .raw        (raw_c),
    .current    (data_in),
    .filtered_c (next_in_c)
  );
`else
  assign next_in_c = raw_c;
`endif

  // Next-state and next pin levels; everything moves only on a divider tick.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    sclk_d  = SHIFT_CLK;
    sload_d = SHIFT_LOAD;
    sout_d  = SHIFT_OUT;
    if (tick_c) begin
      unique case (state_q)
        IDLE: begin
          if (enable) begin
            state_d = LOAD;
            tx_d    = tx_snap_c;
            sload_d = 1'b0;
            sclk_d  = 1'b0;
            sout_d  = tx_snap_c[N-1];
          end
        end
        LOAD: begin
          state_d = SHIFT;
          phase_d = '0;
          sload_d = 1'b1;
          sclk_d  = 1'b0;
          sout_d  = tx_q[N-1];
        end
        SHIFT: begin
          if (!phase_q[0]) begin
            rx_d    = N'({rx_q, SHIFT_IN});
            sclk_d  = 1'b1;
            phase_d = phase_q + PH_W'(1);
          end else if (phase_q == PH_W'(PHASES - 1)) begin
            state_d = LATCH;
            sclk_d  = 1'b0;
            sload_d = 1'b0;
            sout_d  = 1'b0;
          end else begin
            tx_d    = tx_q << 1;
            sout_d  = tx_d[N-1];
            sclk_d  = 1'b0;
            phase_d = phase_q + PH_W'(1);
          end
        end
        LATCH: begin
          sclk_d = 1'b0;
          if (enable) begin
            state_d = LOAD;
            tx_d    = tx_snap_c;
            sload_d = 1'b0;
            sout_d  = tx_snap_c[N-1];
          end else begin
            state_d = IDLE;
            sload_d = 1'b1;
            sout_d  = 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q      <= '0;
      state_q    <= IDLE;
      phase_q    <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      SHIFT_CLK  <= 1'b0;
      SHIFT_LOAD <= 1'b1;
      SHIFT_OUT  <= 1'b0;
      data_in    <= '0;
      frame_done <= 1'b0;
      in_changed <= 1'b0;
    end else begin
      div_q      <= tick_c ? '0 : div_q + DIV_W'(1);
      state_q    <= state_d;
      phase_q    <= phase_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      SHIFT_CLK  <= sclk_d;
      SHIFT_LOAD <= sload_d;
      SHIFT_OUT  <= sout_d;
      frame_done <= frame_end_c;
      in_changed <= frame_end_c && (next_in_c != data_in);
      if (frame_end_c) data_in <= next_in_c;
    end
  end

endmodule

// File: tb/tb_expansion_shiftreg_multi.sv
// Bench for expansion_shiftreg_multi: two instances (8/8 and 12-in/4-out) against 74HC595/165
// device models and a frame-level reference model of data_in.
module tb_expansion_shiftreg_multi;

  localparam int unsigned DIV    = 4;
  localparam int unsigned DEB    = 3;
  localparam int unsigned FRAME8 = (2 * 8 + 2) * DIV;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       en8 = 1'b0, safe8 = 1'b0;
  logic [7:0] dout8 = '0, din8;
  logic       fd8, ic8, so8, si8, sc8, sl8;

  logic        en12 = 1'b0, safe12 = 1'b0;
  logic [3:0]  dout12 = '0;
  logic [11:0] din12;
  logic        fd12, ic12, so12, si12, sc12, sl12;

  expansion_shiftreg_multi #(
    .IN_WIDTH(8), .OUT_WIDTH(8), .DIVIDER(DIV), .SAFE_VALUE(8'h00), .DEB_FRAMES(DEB)
  ) u8 (
    .clk(clk), .rst_n(rst_n), .enable(en8), .safe(safe8), .data_out(dout8), .data_in(din8),
    .frame_done(fd8), .in_changed(ic8), .SHIFT_OUT(so8), .SHIFT_IN(si8), .SHIFT_CLK(sc8),
    .SHIFT_LOAD(sl8)
  );

  expansion_shiftreg_multi #(
    .IN_WIDTH(12), .OUT_WIDTH(4), .DIVIDER(DIV), .SAFE_VALUE(4'h0), .DEB_FRAMES(DEB)
  ) u12 (
    .clk(clk), .rst_n(rst_n), .enable(en12), .safe(safe12), .data_out(dout12), .data_in(din12),
    .frame_done(fd12), .in_changed(ic12), .SHIFT_OUT(so12), .SHIFT_IN(si12), .SHIFT_CLK(sc12),
    .SHIFT_LOAD(sl12)
  );

  // Device models: 165 loads while PL low, shifts on SCK rise; 595 shifts on SCK rise, latches on RCLK rise.
  logic [7:0]  p165_8 = '0, sh165_8 = '0, sh595_8 = '0, q595_8 = '0;
  logic [11:0] p165_12 = '0, sh165_12 = '0;
  logic [3:0]  sh595_12 = '0, q595_12 = '0;
  logic        log8[$];
  logic        log12[$];

  always @(posedge sc8 or negedge sl8)
    if (!sl8) sh165_8 <= p165_8; else sh165_8 <= {sh165_8[6:0], 1'b0};
  always @(posedge sc12 or negedge sl12)
    if (!sl12) sh165_12 <= p165_12; else sh165_12 <= {sh165_12[10:0], 1'b0};
  assign si8  = sh165_8[7];
  assign si12 = sh165_12[11];

  always @(posedge sc8) begin sh595_8 <= {sh595_8[6:0], so8}; log8.push_back(so8); end
  always @(posedge sc12) begin sh595_12 <= {sh595_12[2:0], so12}; log12.push_back(so12); end
  always @(posedge sl8) q595_8 <= sh595_8;
  always @(posedge sl12) q595_12 <= sh595_12;

  int checks = 0;
  int passed = 0;

  // Frame-level data_in model: raw capture, or a bit flips once the last DEB captures all disagree.
  logic [11:0] m_stab [2];
  logic [11:0] m_last [2][DEB];
  int          m_nfr  [2];

  task automatic model_reset();
    for (int id = 0; id < 2; id++) begin
      m_stab[id] = '0;
      m_nfr[id]  = 0;
      for (int j = 0; j < DEB; j++) m_last[id][j] = '0;
    end
  endtask

  task automatic model_frame(input int id, input logic [11:0] raw, output logic [11:0] exp,
                             output logic chg);
    logic [11:0] nxt;
    for (int j = DEB - 1; j > 0; j--) m_last[id][j] = m_last[id][j-1];
    m_last[id][0] = raw;
    m_nfr[id]++;
`ifdef EXPANSION_SHIFTREG_DEBOUNCE_EN
    nxt = m_stab[id];
    if (m_nfr[id] >= DEB) begin
      for (int b = 0; b < 12; b++) begin
        logic flip;
        flip = 1'b1;
        for (int j = 0; j < DEB; j++) if (m_last[id][j][b] == m_stab[id][b]) flip = 1'b0;
        if (flip) nxt[b] = ~m_stab[id][b];
      end
    end
`else
    nxt = raw;
`endif
    chg        = (nxt != m_stab[id]);
    m_stab[id] = nxt;
    exp        = nxt;
  endtask

  // Runs one frame on an instance; enable is dropped after drop_k+1 SHIFT_CLK rises (-1: at LOAD).
  task automatic run_frame(input int id, input logic [11:0] pat, input logic [11:0] d,
                           input logic s, input int drop_k, output logic seen,
                           output int start_cyc, output logic [11:0] din, output logic chg,
                           output logic [11:0] latched, output logic [11:0] so_word,
                           output int so_cnt);
    int   cyc, rises;
    logic prev_sc, cur;
    if (id == 0) begin p165_8 = pat[7:0]; dout8 = d[7:0]; safe8 = s; log8.delete(); end
    else begin p165_12 = pat; dout12 = d[3:0]; safe12 = s; log12.delete(); end
    @(negedge clk);
    if (id == 0) en8 = 1'b1; else en12 = 1'b1;
    start_cyc = 0;
    while (((id == 0) ? sl8 : sl12) !== 1'b0 && start_cyc < 4 * DIV) begin
      @(negedge clk);
      start_cyc++;
    end
    rises = 0; prev_sc = 1'b0; cyc = 0;
    while (rises <= drop_k && cyc < 40 * DIV) begin
      @(negedge clk);
      cyc++;
      cur = (id == 0) ? sc8 : sc12;
      if (cur && !prev_sc) rises++;
      prev_sc = cur;
    end
    if (id == 0) en8 = 1'b0; else en12 = 1'b0;
    seen = 1'b0; cyc = 0;
    while (!seen && cyc < 60 * DIV) begin
      @(negedge clk);
      cyc++;
      if (((id == 0) ? fd8 : fd12) === 1'b1) seen = 1'b1;
    end
    din     = (id == 0) ? 12'(din8) : din12;
    chg     = (id == 0) ? ic8 : ic12;
    latched = (id == 0) ? 12'(q595_8) : 12'(q595_12);
    so_cnt  = (id == 0) ? log8.size() : log12.size();
    so_word = '0;
    for (int i = 0; i < so_cnt; i++) so_word = {so_word[10:0], (id == 0) ? log8[i] : log12[i]};
  endtask

  task automatic test_reset();
    int bad;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if ({sl8, sc8, so8, fd8, ic8} !== 5'b10000) $display("FAIL reset_pins8 got=%b want=10000", {sl8, sc8, so8, fd8, ic8}); else passed++;
    checks++; if (din8 !== 8'h00) $display("FAIL reset_din8 got=%h want=00", din8); else passed++;
    checks++; if ({sl12, sc12, so12, fd12, ic12} !== 5'b10000) $display("FAIL reset_pins12 got=%b want=10000", {sl12, sc12, so12, fd12, ic12}); else passed++;
    checks++; if (din12 !== 12'h000) $display("FAIL reset_din12 got=%h want=000", din12); else passed++;
    rst_n = 1'b1;
    bad = 0;
    repeat (6 * DIV) begin
      @(negedge clk);
      if (fd8 !== 1'b0 || sl8 !== 1'b1 || sc8 !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) $display("FAIL idle_quiet got=%0d want=0", bad); else passed++;
  endtask

  task automatic test_basic();
    logic seen, chg, echg; int st, soc; logic [11:0] din, lat, sow, exp;
    run_frame(0, 12'h03C, 12'h0A5, 1'b0, -1, seen, st, din, chg, lat, sow, soc);
    model_frame(0, 12'h03C, exp, echg);
    checks++; if (seen !== 1'b1) $display("FAIL basic_frame_done got=%b want=1", seen); else passed++;
    checks++; if (st > DIV) $display("FAIL basic_start_latency got=%0d want<=%0d", st, DIV); else passed++;
    checks++; if (soc != 8 || sow !== 12'h0A5) $display("FAIL basic_shift_out got=%0d/%h want=8/0a5", soc, sow); else passed++;
    checks++; if (lat !== 12'h0A5) $display("FAIL basic_595 got=%h want=0a5", lat); else passed++;
    checks++; if (din !== exp) $display("FAIL basic_data_in got=%h want=%h", din, exp); else passed++;
    checks++; if (chg !== echg) $display("FAIL basic_in_changed got=%b want=%b", chg, echg); else passed++;
  endtask

  task automatic test_padding();
    logic seen, chg, echg; int st, soc; logic [11:0] din, lat, sow, exp;
    run_frame(1, 12'h9C3, 12'h00F, 1'b0, -1, seen, st, din, chg, lat, sow, soc);
    model_frame(1, 12'h9C3, exp, echg);
    checks++; if (seen !== 1'b1) $display("FAIL pad_frame_done got=%b want=1", seen); else passed++;
    checks++; if (soc != 12 || sow !== 12'h00F) $display("FAIL pad_shift_out got=%0d/%h want=12/00f", soc, sow); else passed++;
    checks++; if (lat !== 12'h00F) $display("FAIL pad_595 got=%h want=00f", lat); else passed++;
    checks++; if (din !== exp) $display("FAIL pad_data_in got=%h want=%h", din, exp); else passed++;
    checks++; if (chg !== echg) $display("FAIL pad_in_changed got=%b want=%b", chg, echg); else passed++;
  endtask

  task automatic test_safe();
    logic seen, chg, echg; int st, soc; logic [11:0] din, lat, sow, exp, pat;
    for (int n = 0; n < 2; n++) begin
      pat = 12'($urandom_range(0, 255));
      run_frame(0, pat, 12'h0FF, (n == 0), -1, seen, st, din, chg, lat, sow, soc);
      model_frame(0, pat, exp, echg);
      checks++; if (lat !== ((n == 0) ? 12'h000 : 12'h0FF)) $display("FAIL safe_595_%0d got=%h want=%h", n, lat, (n == 0) ? 12'h000 : 12'h0FF); else passed++;
      checks++; if (sow !== lat || soc != 8) $display("FAIL safe_shift_out_%0d got=%0d/%h want=8/%h", n, soc, sow, lat); else passed++;
      checks++; if (din !== exp) $display("FAIL safe_data_in_%0d got=%h want=%h", n, din, exp); else passed++;
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] exp; logic echg; int cyc, extra;
    p165_8 = 8'h3C; dout8 = 8'hA5; safe8 = 1'b0;
    @(negedge clk);
    en8 = 1'b1;
    for (int f = 0; f < 3; f++) begin
      cyc = 0;
      do begin @(negedge clk); cyc++; end while (fd8 !== 1'b1 && cyc < 60 * DIV);
      if (f == 1) begin
        en8 = 1'b0;
        checks++; if (cyc != FRAME8) $display("FAIL b2b_period got=%0d want=%0d", cyc, FRAME8); else passed++;
      end
      model_frame(0, 12'h03C, exp, echg);
      checks++; if (12'(din8) !== exp || fd8 !== 1'b1) $display("FAIL b2b_data_in_%0d got=%h/%b want=%h/1", f, din8, fd8, exp); else passed++;
    end
    extra = 0;
    repeat (2 * FRAME8) begin @(negedge clk); if (fd8 === 1'b1) extra++; end
    checks++; if (extra !== 0 || sl8 !== 1'b1) $display("FAIL b2b_stops got=%0d/%b want=0/1", extra, sl8); else passed++;
    checks++; if (q595_8 !== 8'hA5) $display("FAIL b2b_595 got=%h want=a5", q595_8); else passed++;
  endtask

  task automatic test_enable_drop();
    logic seen, chg, echg; int st, soc, extra; logic [11:0] din, lat, sow, exp;
    run_frame(0, 12'h0C6, 12'h05A, 1'b0, 3, seen, st, din, chg, lat, sow, soc);
    model_frame(0, 12'h0C6, exp, echg);
    checks++; if (seen !== 1'b1 || din !== exp) $display("FAIL drop_frame got=%b/%h want=1/%h", seen, din, exp); else passed++;
    checks++; if (lat !== 12'h05A || sow !== 12'h05A) $display("FAIL drop_595 got=%h/%h want=05a", lat, sow); else passed++;
    extra = 0;
    repeat (2 * FRAME8) begin @(negedge clk); if (fd8 === 1'b1) extra++; end
    checks++; if ({extra, sl8, sc8} !== {32'd0, 2'b10}) $display("FAIL drop_idle got=%0d/%b%b want=0/10", extra, sl8, sc8); else passed++;
  endtask

  task automatic test_glitch();
    logic [7:0]  seq [10] = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 8'h01, 8'h01, 8'h01, 8'h01};
    logic seen, chg, echg; int st, soc; logic [11:0] din, lat, sow, exp;
    for (int n = 0; n < 10; n++) begin
      run_frame(0, 12'(seq[n]), 12'h000, 1'b0, -1, seen, st, din, chg, lat, sow, soc);
      model_frame(0, 12'(seq[n]), exp, echg);
      checks++; if (din !== exp || seen !== 1'b1) $display("FAIL glitch_data_in_%0d got=%h/%b want=%h/1", n, din, seen, exp); else passed++;
      checks++; if (chg !== echg) $display("FAIL glitch_in_changed_%0d got=%b want=%b", n, chg, echg); else passed++;
    end
  endtask

  task automatic test_random();
    logic seen, chg, echg, s; int st, soc, id; logic [11:0] din, lat, sow, exp, pat, d, want;
    for (int n = 0; n < 8; n++) begin
      id  = int'($urandom_range(0, 1));
      pat = 12'($urandom);
      d   = 12'($urandom);
      s   = ($urandom_range(0, 3) == 0);
      if (id == 0) begin pat = pat & 12'h0FF; d = d & 12'h0FF; end
      else d = d & 12'h00F;
      want = s ? 12'h000 : d;
      run_frame(id, pat, d, s, -1, seen, st, din, chg, lat, sow, soc);
      model_frame(id, pat, exp, echg);
      checks++; if (din !== exp || seen !== 1'b1) $display("FAIL rand_data_in_%0d got=%h/%b want=%h/1", n, din, seen, exp); else passed++;
      checks++; if (chg !== echg) $display("FAIL rand_in_changed_%0d got=%b want=%b", n, chg, echg); else passed++;
      checks++; if (lat !== want) $display("FAIL rand_595_%0d got=%h want=%h", n, lat, want); else passed++;
      checks++; if (sow !== want || soc != ((id == 0) ? 8 : 12)) $display("FAIL rand_shift_out_%0d got=%0d/%h want=%h", n, soc, sow, want); else passed++;
    end
  endtask

  task automatic test_reset_mid_shift();
    logic seen, chg, echg, prev_sc; int st, soc, rises, cyc; logic [11:0] din, lat, sow, exp;
    p165_8 = 8'hFF; dout8 = 8'hFF; safe8 = 1'b0;
    @(negedge clk);
    en8 = 1'b1;
    rises = 0; prev_sc = 1'b0; cyc = 0;
    while (rises < 3 && cyc < 40 * DIV) begin
      @(negedge clk);
      cyc++;
      if (sc8 && !prev_sc) rises++;
      prev_sc = sc8;
    end
    checks++; if (rises != 3) $display("FAIL rst_mid_reach got=%0d want=3", rises); else passed++;
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({sl8, sc8, so8, fd8, ic8} !== 5'b10000) $display("FAIL rst_mid_pins got=%b want=10000", {sl8, sc8, so8, fd8, ic8}); else passed++;
    checks++; if (din8 !== 8'h00 || din12 !== 12'h000) $display("FAIL rst_mid_data_in got=%h/%h want=00/000", din8, din12); else passed++;
    en8 = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(0, 12'h05A, 12'h03C, 1'b0, -1, seen, st, din, chg, lat, sow, soc);
    model_frame(0, 12'h05A, exp, echg);
    checks++; if (seen !== 1'b1 || din !== exp || chg !== echg) $display("FAIL rst_mid_resume got=%b/%h/%b want=1/%h/%b", seen, din, chg, exp, echg); else passed++;
    checks++; if (lat !== 12'h03C || soc != 8) $display("FAIL rst_mid_595 got=%h/%0d want=03c/8", lat, soc); else passed++;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_padding();
    test_safe();
    test_back_to_back();
    test_enable_drop();
    test_glitch();
    test_random();
    test_reset_mid_shift();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
